// File: rtl/circuito_gravador_sequencia_pkg.sv
// Shared definitions for the sequence-recorder datapath and its control unit.
// State codes are shared with the other game control units so db_estado reads the same everywhere.
package circuito_gravador_sequencia_pkg;

    localparam int DATA_W_DEF = 4;
    localparam int ADDR_W_DEF = 4;

    typedef enum logic [3:0] {
        INICIAL    = 4'h0,
        PREPARACAO = 4'h1,
        ESPERA     = 4'h2,
        REGISTRA   = 4'h3,
        PROXIMO    = 4'h4,
        FIM        = 4'hF
    } estado_t;

    function automatic logic estado_gravando(input estado_t estado);
        return (estado == ESPERA) || (estado == REGISTRA) || (estado == PROXIMO);
    endfunction

endpackage

// File: rtl/circuito_gravador_sequencia_uc.sv
// Control unit of the recorder: gravar edge detector and session FSM.
// Control outputs are registered from the next state so they line up with the state they belong to.
module gravador_unidade_controle
    import circuito_gravador_sequencia_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       gravar,
    input  logic       fim_c,
    output logic       zera_c,
    output logic       conta_c,
    output logic       escreve_m,
    output logic       zera_m,
    output logic       pronto,
    output logic       gravando,
    output logic [3:0] estado
);

    estado_t estado_reg;
    estado_t estado_next;
    logic    gravar_q_reg;
    logic    borda;
    logic    zera_reg;
    logic    conta_reg;
    logic    escreve_reg;
    logic    pronto_reg;
    logic    gravando_reg;

    assign borda = gravar & ~gravar_q_reg;

    always_comb begin
        estado_next = estado_reg;
        case (estado_reg)
            INICIAL:    if (iniciar) estado_next = PREPARACAO;
            PREPARACAO: estado_next = ESPERA;
            ESPERA:     if (borda) estado_next = REGISTRA;
            REGISTRA:   estado_next = PROXIMO;
            PROXIMO:    estado_next = fim_c ? FIM : ESPERA;
            FIM:        if (iniciar) estado_next = PREPARACAO;
            default:    estado_next = INICIAL;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            estado_reg   <= INICIAL;
            gravar_q_reg <= 1'b0;
            zera_reg     <= 1'b0;
            conta_reg    <= 1'b0;
            escreve_reg  <= 1'b0;
            pronto_reg   <= 1'b0;
            gravando_reg <= 1'b0;
        end else begin
            estado_reg   <= estado_next;
            gravar_q_reg <= gravar;
            zera_reg     <= (estado_next == PREPARACAO);
            escreve_reg  <= (estado_next == REGISTRA);
            // The counter is stable through registra/proximo, so fim_c here already reflects proximo.
            conta_reg    <= (estado_next == PROXIMO) && !fim_c;
            pronto_reg   <= (estado_next == FIM);
            gravando_reg <= estado_gravando(estado_next);
        end
    end

    assign zera_c    = zera_reg;
    assign zera_m    = zera_reg;
    assign conta_c   = conta_reg;
    assign escreve_m = escreve_reg;
    assign pronto    = pronto_reg;
    assign gravando  = gravando_reg;
    assign estado    = estado_reg;

endmodule

// File: rtl/hexa7seg.sv
// Hex digit to 7-segment decoder, active-low segments ordered {g,f,e,d,c,b,a}.
module hexa7seg (
    input  logic [3:0] hexa,
    output logic [6:0] display
);

    always_comb begin
        display = 7'b1111111;
        case (hexa)
            4'h0: display = 7'b1000000;
            4'h1: display = 7'b1111001;
            4'h2: display = 7'b0100100;
            4'h3: display = 7'b0110000;
            4'h4: display = 7'b0011001;
            4'h5: display = 7'b0010010;
            4'h6: display = 7'b0000010;
            4'h7: display = 7'b1111000;
            4'h8: display = 7'b0000000;
            4'h9: display = 7'b0010000;
            4'hA: display = 7'b0001000;
            4'hB: display = 7'b0000011;
            4'hC: display = 7'b1000110;
            4'hD: display = 7'b0100001;
            4'hE: display = 7'b0000110;
            4'hF: display = 7'b0001110;
            default: display = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/circuito_gravador_sequencia.sv
// Sequence recorder: stores one switch value per gravar press into a clearable register file
// and exposes it through a registered read port for the comparison circuit.
module circuito_gravador_sequencia
    import circuito_gravador_sequencia_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int TAMANHO = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic              gravar,
    input  logic [DATA_W-1:0] chaves,
    input  logic [ADDR_W-1:0] rd_endereco,
    output logic [DATA_W-1:0] rd_dado,
    output logic              pronto,
    output logic              gravando,
    output logic              db_gravar,
    output logic [6:0]        db_contagem,
    output logic [6:0]        db_chaves,
    output logic [6:0]        db_estado
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ULTIMO = ADDR_W'(TAMANHO - 1);

    logic              zera_c;
    logic              conta_c;
    logic              escreve_m;
    logic              zera_m;
    logic              fim_c;
    logic [3:0]        estado;
    logic [ADDR_W-1:0] contagem_reg;
    logic [DATA_W-1:0] rd_dado_reg;
    logic [DATA_W-1:0] leitura [DEPTH];

    gravador_unidade_controle u_uc (
        .clock     (clock),
        .reset     (reset),
        .iniciar   (iniciar),
        .gravar    (gravar),
        .fim_c     (fim_c),
        .zera_c    (zera_c),
        .conta_c   (conta_c),
        .escreve_m (escreve_m),
        .zera_m    (zera_m),
        .pronto    (pronto),
        .gravando  (gravando),
        .estado    (estado)
    );

    assign fim_c = (contagem_reg == ULTIMO);

    always_ff @(posedge clock) begin
        if (!reset || zera_c) begin
            contagem_reg <= '0;
        end else if (conta_c) begin
            contagem_reg <= contagem_reg + 1'b1;
        end
    end

    // Each word is its own register so the whole memory can be cleared in a single cycle.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_palavra
            logic [DATA_W-1:0] palavra_reg;

            always_ff @(posedge clock) begin
                if (!reset || zera_m) begin
                    palavra_reg <= '0;
                end else if (escreve_m && (contagem_reg == ADDR_W'(gi))) begin
                    palavra_reg <= chaves;
                end
            end

            assign leitura[gi] = palavra_reg;
        end
    endgenerate

    // Reads see the word before any write committed on the same edge.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_dado_reg <= '0;
        end else begin
            rd_dado_reg <= leitura[rd_endereco];
        end
    end

    assign rd_dado   = rd_dado_reg;
    assign db_gravar = gravar;

    hexa7seg u_hex_contagem (
        .hexa    (4'(contagem_reg)),
        .display (db_contagem)
    );

    hexa7seg u_hex_chaves (
        .hexa    (4'(chaves)),
        .display (db_chaves)
    );

    hexa7seg u_hex_estado (
        .hexa    (estado),
        .display (db_estado)
    );

endmodule

// File: tb/tb_circuito_gravador_sequencia.sv
// Self-checking bench for the sequence recorder; a TAMANHO=4 instance shares the stimulus.
module tb_circuito_gravador_sequencia;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       iniciar = 1'b0;
    logic       gravar = 1'b0;
    logic [3:0] chaves = 4'h0;
    logic [3:0] rd_endereco = 4'h0;

    logic [3:0] rd_dado, rd_dado4;
    logic       pronto, gravando, db_gravar;
    logic       pronto4, gravando4, db_gravar4;
    logic [6:0] db_contagem, db_chaves, db_estado;
    logic [6:0] db_contagem4, db_chaves4, db_estado4;

    always #5 clock = ~clock;

    circuito_gravador_sequencia #(.DATA_W(4), .ADDR_W(4), .TAMANHO(16)) u_dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .gravar(gravar),
        .chaves(chaves), .rd_endereco(rd_endereco), .rd_dado(rd_dado),
        .pronto(pronto), .gravando(gravando), .db_gravar(db_gravar),
        .db_contagem(db_contagem), .db_chaves(db_chaves), .db_estado(db_estado)
    );

    circuito_gravador_sequencia #(.DATA_W(4), .ADDR_W(4), .TAMANHO(4)) u_dut4 (
        .clock(clock), .reset(reset), .iniciar(iniciar), .gravar(gravar),
        .chaves(chaves), .rd_endereco(rd_endereco), .rd_dado(rd_dado4),
        .pronto(pronto4), .gravando(gravando4), .db_gravar(db_gravar4),
        .db_contagem(db_contagem4), .db_chaves(db_chaves4), .db_estado(db_estado4)
    );

    typedef struct {
        logic [3:0] d16;
        logic [3:0] d4;
    } esperado_t;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [3:0]  mm [2][16];
    int          mcnt [2];
    logic        mfim [2];
    int          tam [2] = '{16, 4};
    esperado_t   fila [$];
    logic [3:0]  valores [14] = '{4'h3, 4'h7, 4'hA, 4'h1, 4'hC, 4'h4, 4'hE,
                                  4'h0, 4'hB, 4'h6, 4'hD, 4'h8, 4'hF, 4'h2};

    function automatic logic [6:0] seg(input logic [3:0] v);
        case (v)
            4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic limpa_modelo();
        for (int k = 0; k < 2; k++) begin
            for (int a = 0; a < 16; a++) mm[k][a] = 4'h0;
            mcnt[k] = 0;
            mfim[k] = 1'b0;
        end
    endtask

    task automatic modela(input logic [3:0] v);
        for (int k = 0; k < 2; k++) begin
            if (!mfim[k]) begin
                mm[k][mcnt[k]] = v;
                if (mcnt[k] == tam[k] - 1) mfim[k] = 1'b1;
                else mcnt[k]++;
            end
        end
    endtask

    task automatic verifica_estado(input string tag, input logic [3:0] est, input logic [3:0] cnt,
                                   input logic pr, input logic gr);
        verifica({tag, ".estado"}, db_estado, seg(est));
        verifica({tag, ".contagem"}, db_contagem, seg(cnt));
        verifica({tag, ".pronto"}, pronto, pr);
        verifica({tag, ".gravando"}, gravando, gr);
    endtask

    // One press: edge k -> registra, k+1 write, k+2 counter/fim; returns in espera (or fim).
    task automatic grava(input logic [3:0] v);
        @(negedge clock); chaves = v; gravar = 1'b1;
        @(negedge clock); gravar = 1'b0;
        @(negedge clock);
        @(negedge clock);
        $display("grava: addr=%0d val=%h", mcnt[0], v);
        modela(v);
    endtask

    task automatic le(input string tag, input int a);
        esperado_t e;
        @(negedge clock);
        rd_endereco = 4'(a);
        fila.push_back('{d16: mm[0][a], d4: mm[1][a]});
        @(posedge clock); #1;
        e = fila.pop_front();
        verifica($sformatf("%s.rd[%0d]", tag, a), rd_dado, e.d16);
        verifica($sformatf("%s.rd4[%0d]", tag, a), rd_dado4, e.d4);
    endtask

    task automatic le_tudo(input string tag);
        for (int a = 0; a < 16; a++) le(tag, a);
        $display("leitura: %s 16 enderecos", tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        limpa_modelo();
        repeat (2) @(posedge clock);
        @(negedge clock); reset = 1'b1;
        verifica_estado("reset", 4'h0, 4'h0, 1'b0, 1'b0);
        verifica("reset.db_gravar", db_gravar, 1'b0);
        verifica("reset.db_chaves", db_chaves, seg(4'h0));
        le_tudo("reset");

        @(negedge clock); iniciar = 1'b1;
        @(posedge clock); #1;
        verifica_estado("prep", 4'h1, 4'h0, 1'b0, 1'b0);
        @(negedge clock); iniciar = 1'b0;
        @(posedge clock); #1;
        verifica_estado("espera", 4'h2, 4'h0, 1'b0, 1'b1);

        // gravar held high for 10 cycles must write once
        @(negedge clock); chaves = 4'h5; gravar = 1'b1;
        #1;
        verifica("hold.db_gravar", db_gravar, 1'b1);
        verifica("hold.db_chaves", db_chaves, seg(4'h5));
        repeat (10) @(negedge clock);
        gravar = 1'b0;
        @(negedge clock);
        modela(4'h5);
        $display("grava: addr=0 val=5 (held 10 cycles)");
        verifica_estado("hold", 4'h2, 4'h1, 1'b0, 1'b1);

        // chaves changes after the write edge: the earlier value is kept
        @(negedge clock); chaves = 4'h2; gravar = 1'b1;
        @(negedge clock); gravar = 1'b0;
        @(negedge clock); chaves = 4'h9;
        @(negedge clock);
        modela(4'h2);
        $display("grava: addr=1 val=2 (chaves->9 afterwards)");
        le("troca", 1);

        for (int i = 0; i < 14; i++) begin
            grava(valores[i]);
            if (i == 1) begin
                verifica("tam4.pronto4", pronto4, mfim[1]);
                verifica("tam4.estado4", db_estado4, seg(4'hF));
                verifica("tam4.pronto16", pronto, mfim[0]);
            end
        end
        verifica_estado("fim", 4'hF, 4'hF, 1'b1, 1'b0);

        grava(4'hE);
        verifica_estado("fim_extra", 4'hF, 4'hF, 1'b1, 1'b0);
        le_tudo("sessao");

        @(negedge clock); iniciar = 1'b1;
        @(posedge clock); #1;
        verifica("novo.estado_prep", db_estado, seg(4'h1));
        verifica("novo.gravando_prep", gravando, 1'b0);
        @(negedge clock); iniciar = 1'b0;
        @(posedge clock); #1;
        limpa_modelo();
        verifica_estado("novo", 4'h2, 4'h0, 1'b0, 1'b1);
        le_tudo("novo");

        @(negedge clock); iniciar = 1'b1;
        @(posedge clock); #1;
        verifica("ignora_iniciar.estado", db_estado, seg(4'h2));
        @(negedge clock); iniciar = 1'b0;

        for (int i = 0; i < 5; i++) grava(valores[13 - i]);
        verifica("meio.contagem", db_contagem, seg(4'(mcnt[0])));
        @(negedge clock); reset = 1'b0;
        @(negedge clock); reset = 1'b1;
        limpa_modelo();
        $display("reset no meio da sessao");
        verifica_estado("reset_meio", 4'h0, 4'h0, 1'b0, 1'b0);
        le_tudo("reset_meio");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
